mor1kx_tlb_reload_resp: RTL
===========================

MOR1KX_TLB_RELOAD_RESP -- requirements
Module: mor1kx_tlb_reload_resp

Interface
REQ-001 Parameter OPTION_OPERAND_WIDTH, default 32, SHALL set the width of all address and data ports.
REQ-002 Parameter FEATURE_PTE_CACHE, default "ENABLED", SHALL enable the one-entry read cache; any other value SHALL remove it.
REQ-003 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 dmmu_req_i  input  1  DMMU reload request, level, held until acked or withdrawn.
REQ-006 dmmu_addr_i  input  OPTION_OPERAND_WIDTH  DMMU word address.
REQ-007 dmmu_ack_o  output  1  one-cycle acknowledge to DMMU.
REQ-008 dmmu_data_o  output  OPTION_OPERAND_WIDTH  read data, valid only with dmmu_ack_o.
REQ-009 immu_req_i, immu_addr_i, immu_ack_o, immu_data_o SHALL have the same directions, widths and meanings as REQ-005 to REQ-008, for the IMMU.
REQ-010 wbm_adr_o  output  OPTION_OPERAND_WIDTH  bus address.
REQ-011 wbm_cyc_o, wbm_stb_o  output  1 each  classic bus cycle/strobe.
REQ-012 wbm_we_o  output  1  tied 0; wbm_sel_o  output  4  tied 4'hf.
REQ-013 wbm_dat_i  input  OPTION_OPERAND_WIDTH; wbm_ack_i, wbm_err_i  input  1 each.
REQ-014 cache_flush_i  input  1  invalidates the cache entry.
REQ-015 bus_err_o  output  1  one-cycle pulse on a bus error.

Function
REQ-016 The FSM SHALL have the states IDLE, BUS, RESP and GAP.
REQ-017 In IDLE with exactly one request high, the block SHALL grant that requester and latch its address.
REQ-018 In IDLE with both requests high, the block SHALL grant the requester not granted last; after reset, DMMU has priority.
REQ-019 On a grant in cycle T with a cache hit (entry valid and address equal), the FSM SHALL go to RESP; the owner's ack and the cached data SHALL be driven in T+1, with no bus cycle.
REQ-020 On a grant in cycle T with a miss, the FSM SHALL go to BUS; wbm_cyc_o and wbm_stb_o SHALL be high with the latched address from T+1 until the cycle in which wbm_ack_i or wbm_err_i is sampled, inclusive.
REQ-021 When wbm_ack_i is sampled in BUS, the block SHALL register wbm_dat_i, fill the cache with {address, data}, and pulse the owner's ack with that data in the next cycle (RESP).
REQ-022 When wbm_err_i is sampled in BUS, the block SHALL ack the owner with all-zero data, pulse bus_err_o in the same cycle, and SHALL NOT fill the cache; zero data is a page fault for both MMUs.
REQ-023 If wbm_ack_i and wbm_err_i are high together, the access SHALL be treated as an error.
REQ-024 If the owner's request is low when the bus response is sampled, the block SHALL finish the bus cycle, suppress the ack, still fill on a valid ack, and go to GAP.
REQ-025 RESP SHALL always go to GAP; GAP SHALL last exactly one cycle and then return to IDLE. This lets the requester update its address for a second-level fetch or drop its request.
REQ-026 Acks SHALL be one cycle wide; the two acks SHALL never be high together; the data output of a requester not being acked SHALL be 0.
REQ-027 cache_flush_i SHALL clear the valid bit the next cycle; if it coincides with a fill, the flush SHALL take priority.
REQ-028 Minimum request-to-request spacing for one requester SHALL be 3 cycles on a hit and 4 cycles plus bus wait states on a miss.

Reset
REQ-029 While rst_n is low, the FSM SHALL be IDLE, all outputs except wbm_sel_o SHALL be 0, the cache SHALL be invalid, and the last-grant flag SHALL indicate IMMU.
REQ-030 Reset asserted mid-access SHALL drop wbm_cyc_o and wbm_stb_o immediately and SHALL produce no ack.

Structure
REQ-031 The FSM state encodings (2-bit) SHALL live in the shared defines file alongside the existing MMU constants.
REQ-032 The cache entry and comparator SHALL be a sub-module, mor1kx_pte_cache1, removed by generate when FEATURE_PTE_CACHE is not "ENABLED".

Verification
REQ-033 The bench SHALL cover a DMMU miss: addr 0x00001004, bus acks after 2 wait states with 0xDEAD2400 -> one cyc/stb window of 3 cycles, then dmmu_ack_o with 0xDEAD2400 one cycle later.
REQ-034 The bench SHALL cover a repeat hit: same address after GAP -> dmmu_ack_o with 0xDEAD2400 one cycle after the grant, wbm_cyc_o stays 0.
REQ-035 The bench SHALL cover simultaneous requests, both held for 3 rounds -> grants alternate DMMU, IMMU, DMMU.
REQ-036 The bench SHALL cover a bus error: wbm_err_i on an IMMU access -> immu_ack_o with data 0x0 and bus_err_o pulse in the same cycle, and the next identical request misses.
REQ-037 The bench SHALL cover withdrawal and flush: DMMU drops its request during BUS -> no ack, GAP observed; cache_flush_i during a fill -> the next identical request misses.

Source files
------------

// File: rtl/mor1kx_tlb_reload_resp_pkg.sv
// Shared MMU constants for the TLB reload responder: FSM encodings, owner
// identifiers and the fixed bus byte-select.
package mor1kx_tlb_reload_resp_pkg;

  localparam logic [1:0] TLB_RELOAD_IDLE = 2'd0;
  localparam logic [1:0] TLB_RELOAD_BUS  = 2'd1;
  localparam logic [1:0] TLB_RELOAD_RESP = 2'd2;
  localparam logic [1:0] TLB_RELOAD_GAP  = 2'd3;

  localparam logic OWNER_DMMU = 1'b0;
  localparam logic OWNER_IMMU = 1'b1;

  localparam logic [3:0] WB_SEL_WORD = 4'hf;

endpackage

// File: rtl/mor1kx_pte_cache1.sv
// One-entry PTE read cache: a single {address, data} pair with a valid bit.
// A flush in the same cycle as a fill leaves the entry invalid.
module mor1kx_pte_cache1
  import mor1kx_tlb_reload_resp_pkg::*;
#(
  parameter int OPTION_OPERAND_WIDTH = 32
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            flush_i,
  input  logic                            fill_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] fill_addr_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] fill_data_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] lookup_addr_i,
  output logic                            hit_o,
  output logic [OPTION_OPERAND_WIDTH-1:0] hit_data_o
);

  logic                            valid_q;
  logic [OPTION_OPERAND_WIDTH-1:0] tag_q;
  logic [OPTION_OPERAND_WIDTH-1:0] data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      tag_q   <= '0;
      data_q  <= '0;
    end else begin
      if (fill_i) begin
        tag_q  <= fill_addr_i;
        data_q <= fill_data_i;
      end
      if (flush_i)
        valid_q <= 1'b0;
      else if (fill_i)
        valid_q <= 1'b1;
    end
  end

  assign hit_o      = valid_q && (tag_q == lookup_addr_i);
  assign hit_data_o = data_q;

endmodule

// File: rtl/mor1kx_tlb_reload_resp.sv
// Arbitrates DMMU/IMMU page-table reloads onto one classic bus master, with an
// optional one-entry PTE cache that answers repeat reads without a bus cycle.
module mor1kx_tlb_reload_resp
  import mor1kx_tlb_reload_resp_pkg::*;
#(
  parameter int OPTION_OPERAND_WIDTH = 32,
  parameter     FEATURE_PTE_CACHE    = "ENABLED"
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            dmmu_req_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] dmmu_addr_i,
  output logic                            dmmu_ack_o,
  output logic [OPTION_OPERAND_WIDTH-1:0] dmmu_data_o,
  input  logic                            immu_req_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] immu_addr_i,
  output logic                            immu_ack_o,
  output logic [OPTION_OPERAND_WIDTH-1:0] immu_data_o,
  output logic [OPTION_OPERAND_WIDTH-1:0] wbm_adr_o,
  output logic                            wbm_cyc_o,
  output logic                            wbm_stb_o,
  output logic                            wbm_we_o,
  output logic [3:0]                      wbm_sel_o,
  input  logic [OPTION_OPERAND_WIDTH-1:0] wbm_dat_i,
  input  logic                            wbm_ack_i,
  input  logic                            wbm_err_i,
  input  logic                            cache_flush_i,
  output logic                            bus_err_o
);

  logic [1:0]                      state_q, state_d;
  logic                            owner_q, owner_d;
  logic                            last_grant_q, last_grant_d;
  logic                            err_q, err_d;
  logic [OPTION_OPERAND_WIDTH-1:0] addr_q, addr_d;
  logic [OPTION_OPERAND_WIDTH-1:0] data_q, data_d;

  logic                            any_req;
  logic                            grant_immu;
  logic                            owner_req;
  logic                            bus_done;
  logic                            fill;
  logic                            cache_hit;
  logic [OPTION_OPERAND_WIDTH-1:0] lookup_addr;
  logic [OPTION_OPERAND_WIDTH-1:0] cache_data;

  // On contention the requester that was not granted last wins.
  assign any_req     = dmmu_req_i | immu_req_i;
  assign grant_immu  = immu_req_i & (~dmmu_req_i | (last_grant_q == OWNER_DMMU));
  assign lookup_addr = grant_immu ? immu_addr_i : dmmu_addr_i;
  assign owner_req   = (owner_q == OWNER_IMMU) ? immu_req_i : dmmu_req_i;
  assign bus_done    = wbm_ack_i | wbm_err_i;
  assign fill        = (state_q == TLB_RELOAD_BUS) & wbm_ack_i & ~wbm_err_i;

  generate
    if (FEATURE_PTE_CACHE == "ENABLED") begin : g_pte_cache
      mor1kx_pte_cache1 #(
        .OPTION_OPERAND_WIDTH(OPTION_OPERAND_WIDTH)
      ) u_pte_cache1 (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush_i      (cache_flush_i),
        .fill_i       (fill),
        .fill_addr_i  (addr_q),
        .fill_data_i  (wbm_dat_i),
        .lookup_addr_i(lookup_addr),
        .hit_o        (cache_hit),
        .hit_data_o   (cache_data)
      );
    end else begin : g_no_pte_cache
      assign cache_hit  = 1'b0;
      assign cache_data = '0;
    end
  endgenerate

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    err_d        = 1'b0;
    addr_d       = addr_q;
    data_d       = data_q;
    case (state_q)
      TLB_RELOAD_IDLE: begin
        if (any_req) begin
          owner_d      = grant_immu;
          last_grant_d = grant_immu;
          addr_d       = lookup_addr;
          if (cache_hit) begin
            data_d  = cache_data;
            state_d = TLB_RELOAD_RESP;
          end else begin
            state_d = TLB_RELOAD_BUS;
          end
        end
      end
      TLB_RELOAD_BUS: begin
        // An error wins over a simultaneous ack and reads as a zero PTE.
        if (bus_done) begin
          data_d  = wbm_err_i ? '0 : wbm_dat_i;
          err_d   = wbm_err_i;
          state_d = owner_req ? TLB_RELOAD_RESP : TLB_RELOAD_GAP;
        end
      end
      TLB_RELOAD_RESP: state_d = TLB_RELOAD_GAP;
      default:         state_d = TLB_RELOAD_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= TLB_RELOAD_IDLE;
      owner_q      <= OWNER_DMMU;
      last_grant_q <= OWNER_IMMU;
      err_q        <= 1'b0;
      addr_q       <= '0;
      data_q       <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      err_q        <= err_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
    end
  end

  assign dmmu_ack_o  = (state_q == TLB_RELOAD_RESP) && (owner_q == OWNER_DMMU);
  assign immu_ack_o  = (state_q == TLB_RELOAD_RESP) && (owner_q == OWNER_IMMU);
  assign dmmu_data_o = dmmu_ack_o ? data_q : '0;
  assign immu_data_o = immu_ack_o ? data_q : '0;

  assign wbm_cyc_o = (state_q == TLB_RELOAD_BUS);
  assign wbm_stb_o = (state_q == TLB_RELOAD_BUS);
  assign wbm_adr_o = addr_q;
  assign wbm_we_o  = 1'b0;
  assign wbm_sel_o = WB_SEL_WORD;
  assign bus_err_o = err_q;

endmodule
